// File: rtl/instr_fetch_if.sv
// Load-port and CPU fetch-port bundle for the instruction fetch unit.
// master = program source / CPU side, slave = instr_fetch_unit.
interface instr_fetch_if #(
  parameter int AW = 4
);
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_last;
  logic          load_ready;
  logic          reload;
  logic [7:0]    pc;
  logic [7:0]    instruction;
  logic          instr_valid;
  logic          cpu_reset;
  logic [AW:0]   prog_len;
  logic          fault;

  modport master (
    output load_valid, load_data, load_last, reload, pc,
    input  load_ready, instruction, instr_valid, cpu_reset, prog_len, fault
  );

  modport slave (
    input  load_valid, load_data, load_last, reload, pc,
    output load_ready, instruction, instr_valid, cpu_reset, prog_len, fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program loader and instruction server: fills a byte store over a valid/ready
// port, then serves one byte per PC and halts the CPU on illegal fetches.
module instr_fetch_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic          clk,
  input logic          reset_n,
  instr_fetch_if.slave bus
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]    state_r;
  logic [AW:0]   prog_len_r;
  logic [7:0]    mem_r [DEPTH];
  logic          load_ready_r;
  logic          cpu_reset_r;
  logic          instr_valid_r;
  logic          fault_r;
  logic [7:0]    instruction_r;

  logic          xfer_s;
  logic          last_xfer_s;
  logic          fetch_ok_s;
  logic [AW-1:0] idx_s;

  // Transfer qualification and fetch legality; prog_len doubles as the write pointer.
  always_comb begin
    idx_s       = bus.pc[AW+1:2];
    xfer_s      = reset_n && load_ready_r && bus.load_valid && !bus.reload;
    last_xfer_s = bus.load_last || (prog_len_r == (AW+1)'(DEPTH - 1));
    fetch_ok_s  = (bus.pc[1:0] == 2'b00) &&
                  ((bus.pc >> (AW + 2)) == 8'h00) &&
                  ({1'b0, idx_s} < prog_len_r);
  end

  // Instruction store: written only on accepted transfers, never cleared.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_r[prog_len_r[AW-1:0]] <= bus.load_data;
    end
  end

  // Control state machine; reload overrides any same-cycle transfer or fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_LOAD;
      prog_len_r    <= '0;
      load_ready_r  <= 1'b1;
      cpu_reset_r   <= 1'b1;
      instr_valid_r <= 1'b0;
      instruction_r <= 8'h00;
      fault_r       <= 1'b0;
    end else if (bus.reload) begin
      state_r       <= ST_LOAD;
      prog_len_r    <= '0;
      load_ready_r  <= 1'b1;
      cpu_reset_r   <= 1'b1;
      instr_valid_r <= 1'b0;
      instruction_r <= 8'h00;
      fault_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (xfer_s) begin
            prog_len_r <= prog_len_r + (AW+1)'(1);
            if (last_xfer_s) begin
              state_r      <= ST_RUN;
              load_ready_r <= 1'b0;
              cpu_reset_r  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (fetch_ok_s) begin
            instruction_r <= mem_r[idx_s];
            instr_valid_r <= 1'b1;
          end else begin
            instruction_r <= 8'h00;
            instr_valid_r <= 1'b0;
            fault_r       <= 1'b1;
            cpu_reset_r   <= 1'b1;
            state_r       <= ST_HALT;
          end
        end
        ST_HALT: begin
          instruction_r <= 8'h00;
          instr_valid_r <= 1'b0;
          cpu_reset_r   <= 1'b1;
          load_ready_r  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely with the CPU held in reset.
          state_r       <= ST_HALT;
          instruction_r <= 8'h00;
          instr_valid_r <= 1'b0;
          cpu_reset_r   <= 1'b1;
          load_ready_r  <= 1'b0;
          fault_r       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready_r;
  assign bus.instruction = instruction_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.cpu_reset   = cpu_reset_r;
  assign bus.prog_len    = prog_len_r;
  assign bus.fault       = fault_r;

endmodule
